// File: rtl/dmi_req_arbiter.sv
// dmi_req_arbiter: shares the Debug Module's single DMI request/response port
// between two masters (m0 = JTAG DTM, m1 = on-chip debug agent). One
// transaction is in flight at a time; the response is routed back to the
// master that owns it. Write completions are generated locally, because the
// DM only returns rsp_valid for reads.
// Optional feature: define DMI_ARB_TIMEOUT_EN to fail a transaction that
// stays in ISSUE/WAIT_RSP for TIMEOUT_CYCLES cycles.
module dmi_req_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        reset_i,

    input  logic        m0_req_valid_i,
    input  logic [1:0]  m0_req_op_i,
    input  logic [6:0]  m0_req_address_i,
    input  logic [31:0] m0_req_data_i,
    output logic        m0_req_ready_o,
    output logic        m0_rsp_valid_o,
    output logic [31:0] m0_rsp_data_o,
    output logic [1:0]  m0_rsp_op_o,

    input  logic        m1_req_valid_i,
    input  logic [1:0]  m1_req_op_i,
    input  logic [6:0]  m1_req_address_i,
    input  logic [31:0] m1_req_data_i,
    output logic        m1_req_ready_o,
    output logic        m1_rsp_valid_o,
    output logic [31:0] m1_rsp_data_o,
    output logic [1:0]  m1_rsp_op_o,

    output logic        dmi_req_valid_o,
    output logic [1:0]  dmi_req_op_o,
    output logic [6:0]  dmi_req_address_o,
    output logic [31:0] dmi_req_data_o,
    input  logic        dmi_req_ready_i,
    input  logic        dmi_rsp_valid_i,
    input  logic [31:0] dmi_rsp_data_i,
    input  logic [1:0]  dmi_rsp_op_i,

    output logic        busy_o,
    output logic        grant_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RESPOND} state_t;

    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] RSP_OK   = 2'b00;
    localparam logic [1:0] RSP_FAIL = 2'b10;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("dmi_req_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    state_t      state_q, state_d;
    logic        last_q;          // owner of current/last transaction, 1 = m1
    logic        owner_d;
    logic [1:0]  hold_op_q;
    logic [6:0]  hold_addr_q;
    logic [31:0] hold_data_q;
    logic        win0, win1, accept;
    logic        load_rsp;
    logic [31:0] rsp_data_d;
    logic [1:0]  rsp_op_d;
    logic        timeout_hit;
    logic [31:0] m0_rsp_data_q, m1_rsp_data_q;
    logic [1:0]  m0_rsp_op_q, m1_rsp_op_q;

`ifdef DMI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt_q;

    // Timeout counter: cleared on acceptance, counts every ISSUE/WAIT_RSP cycle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (state_q == ISSUE || state_q == WAIT_RSP) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign timeout_hit = (state_q == ISSUE || state_q == WAIT_RSP) &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state, arbitration, DM request drive and response selection.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d         = state_q;
        accept          = 1'b0;
        owner_d         = last_q;
        load_rsp        = 1'b0;
        rsp_data_d      = 32'd0;
        rsp_op_d        = RSP_OK;
        dmi_req_valid_o = 1'b0;

        // Round-robin: on a tie the master not granted last time wins.
        win0 = m0_req_valid_i && (!m1_req_valid_i || last_q);
        win1 = m1_req_valid_i && (!m0_req_valid_i || !last_q);

        case (state_q)
            IDLE: begin
                if (win0 || win1) begin
                    accept  = 1'b1;
                    owner_d = win1;
                    // Reserved op 11 is handled like a nop: never sent to the DM.
                    if ((win1 ? m1_req_op_i : m0_req_op_i) inside {OP_READ, OP_WRITE}) begin
                        state_d = ISSUE;
                    end else begin
                        state_d  = RESPOND;
                        load_rsp = 1'b1;
                    end
                end
            end
            ISSUE: begin
                dmi_req_valid_o = !timeout_hit;
                if (!timeout_hit && dmi_req_ready_i) begin
                    if (hold_op_q == OP_WRITE) begin
                        state_d  = RESPOND;
                        load_rsp = 1'b1;
                    end else if (dmi_rsp_valid_i) begin
                        state_d    = RESPOND;
                        load_rsp   = 1'b1;
                        rsp_data_d = dmi_rsp_data_i;
                        rsp_op_d   = dmi_rsp_op_i;
                    end else begin
                        state_d = WAIT_RSP;
                    end
                end else if (timeout_hit) begin
                    state_d  = RESPOND;
                    load_rsp = 1'b1;
                    rsp_op_d = RSP_FAIL;
                end
            end
            WAIT_RSP: begin
                if (dmi_rsp_valid_i) begin
                    state_d    = RESPOND;
                    load_rsp   = 1'b1;
                    rsp_data_d = dmi_rsp_data_i;
                    rsp_op_d   = dmi_rsp_op_i;
                end else if (timeout_hit) begin
                    state_d  = RESPOND;
                    load_rsp = 1'b1;
                    rsp_op_d = RSP_FAIL;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, grant, holding registers and per-master response registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        // NOTE: the holding and response registers are reset as well, so that
        // data/op outputs read 0 after reset rather than stale values.
        if (reset_i) begin
            state_q       <= IDLE;
            last_q        <= 1'b1;
            hold_op_q     <= 2'd0;
            hold_addr_q   <= 7'd0;
            hold_data_q   <= 32'd0;
            m0_rsp_data_q <= 32'd0;
            m0_rsp_op_q   <= 2'd0;
            m1_rsp_data_q <= 32'd0;
            m1_rsp_op_q   <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments, so every register here samples
            // the pre-edge values regardless of statement order.
            state_q <= state_d;
            if (accept) begin
                last_q      <= owner_d;
                hold_op_q   <= owner_d ? m1_req_op_i      : m0_req_op_i;
                hold_addr_q <= owner_d ? m1_req_address_i : m0_req_address_i;
                hold_data_q <= owner_d ? m1_req_data_i    : m0_req_data_i;
            end
            // Only the owner's response registers change, so the other
            // master's data/op stay stable.
            if (load_rsp) begin
                if (owner_d) begin
                    m1_rsp_data_q <= rsp_data_d;
                    m1_rsp_op_q   <= rsp_op_d;
                end else begin
                    m0_rsp_data_q <= rsp_data_d;
                    m0_rsp_op_q   <= rsp_op_d;
                end
            end
        end
    end

    // Readies are masked by reset so nothing is accepted while reset is held.
    assign m0_req_ready_o = !reset_i && (state_q == IDLE) && win0;
    assign m1_req_ready_o = !reset_i && (state_q == IDLE) && win1;

    assign m0_rsp_valid_o = (state_q == RESPOND) && !last_q;
    assign m1_rsp_valid_o = (state_q == RESPOND) &&  last_q;
    assign m0_rsp_data_o  = m0_rsp_data_q;
    assign m0_rsp_op_o    = m0_rsp_op_q;
    assign m1_rsp_data_o  = m1_rsp_data_q;
    assign m1_rsp_op_o    = m1_rsp_op_q;

    assign dmi_req_op_o      = hold_op_q;
    assign dmi_req_address_o = hold_addr_q;
    assign dmi_req_data_o    = hold_data_q;

    assign busy_o  = (state_q != IDLE);
    assign grant_o = last_q;

endmodule

// File: tb/tb_dmi_req_arbiter.sv
// Directed testbench for dmi_req_arbiter. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge.
module tb_dmi_req_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m1_valid;
    logic [1:0]  m0_op, m1_op;
    logic [6:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_ready, m1_ready;
    logic        m0_rsp_valid, m1_rsp_valid;
    logic [31:0] m0_rsp_data, m1_rsp_data;
    logic [1:0]  m0_rsp_op, m1_rsp_op;
    logic        dmi_valid;
    logic [1:0]  dmi_op;
    logic [6:0]  dmi_addr;
    logic [31:0] dmi_data;
    logic        dm_ready, dm_rsp_valid;
    logic [31:0] dm_rsp_data;
    logic [1:0]  dm_rsp_op;
    logic        busy, grant;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmi_req_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk), .reset_i(reset),
        .m0_req_valid_i(m0_valid), .m0_req_op_i(m0_op), .m0_req_address_i(m0_addr),
        .m0_req_data_i(m0_wdata), .m0_req_ready_o(m0_ready), .m0_rsp_valid_o(m0_rsp_valid),
        .m0_rsp_data_o(m0_rsp_data), .m0_rsp_op_o(m0_rsp_op),
        .m1_req_valid_i(m1_valid), .m1_req_op_i(m1_op), .m1_req_address_i(m1_addr),
        .m1_req_data_i(m1_wdata), .m1_req_ready_o(m1_ready), .m1_rsp_valid_o(m1_rsp_valid),
        .m1_rsp_data_o(m1_rsp_data), .m1_rsp_op_o(m1_rsp_op),
        .dmi_req_valid_o(dmi_valid), .dmi_req_op_o(dmi_op), .dmi_req_address_o(dmi_addr),
        .dmi_req_data_o(dmi_data), .dmi_req_ready_i(dm_ready), .dmi_rsp_valid_i(dm_rsp_valid),
        .dmi_rsp_data_i(dm_rsp_data), .dmi_rsp_op_i(dm_rsp_op),
        .busy_o(busy), .grant_o(grant)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    int          k0, k1, exp_m;
    logic [6:0]  exp_addr;

    initial begin
        reset = 1'b1;
        m0_valid = 0; m0_op = 0; m0_addr = 0; m0_wdata = 0;
        m1_valid = 0; m1_op = 0; m1_addr = 0; m1_wdata = 0;
        dm_ready = 0; dm_rsp_valid = 0; dm_rsp_data = 0; dm_rsp_op = 0;

        // ---- reset state ----
        sample();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dmi_valid", 32'(dmi_valid), 32'd0);
        check("rst_grant", 32'(grant), 32'd1);
        check("rst_m0_rsp_data", m0_rsp_data, 32'd0);
        tick();
        reset = 1'b0;

        // ---- m0 read, same-cycle DM ----
        tick();
        m0_valid = 1; m0_op = 2'b01; m0_addr = 7'h11;
        sample();
        check("rd_m0_ready", 32'(m0_ready), 32'd1);
        check("rd_m1_ready", 32'(m1_ready), 32'd0);
        tick();
        m0_valid = 0;
        dm_ready = 1; dm_rsp_valid = 1; dm_rsp_data = 32'h0000_0300; dm_rsp_op = 2'b00;
        sample();
        check("rd_dmi_valid", 32'(dmi_valid), 32'd1);
        check("rd_dmi_addr", 32'(dmi_addr), 32'h11);
        check("rd_dmi_op", 32'(dmi_op), 32'd1);
        check("rd_early_rsp", 32'(m0_rsp_valid), 32'd0);
        tick();
        dm_ready = 0; dm_rsp_valid = 0;
        sample();
        check("rd_m0_rsp_valid", 32'(m0_rsp_valid), 32'd1);
        check("rd_m0_rsp_data", m0_rsp_data, 32'h300);
        check("rd_m0_rsp_op", 32'(m0_rsp_op), 32'd0);
        check("rd_m1_rsp_valid", 32'(m1_rsp_valid), 32'd0);
        check("rd_grant", 32'(grant), 32'd0);
        tick();
        sample();
        check("rd_pulse_end", 32'(m0_rsp_valid), 32'd0);
        check("rd_idle", 32'(busy), 32'd0);
        check("rd_data_hold", m0_rsp_data, 32'h300);

        // ---- m1 write, DM ready low 3 cycles ----
        tick();
        m1_valid = 1; m1_op = 2'b10; m1_addr = 7'h10; m1_wdata = 32'h8000_0001;
        sample();
        check("wr_m1_ready", 32'(m1_ready), 32'd1);
        tick();
        m1_valid = 0;
        for (int i = 0; i < 4; i++) begin
            dm_ready = (i == 3);
            sample();
            check("wr_dmi_valid", 32'(dmi_valid), 32'd1);
            check("wr_dmi_op", 32'(dmi_op), 32'd2);
            check("wr_dmi_addr", 32'(dmi_addr), 32'h10);
            check("wr_dmi_data", dmi_data, 32'h8000_0001);
            check("wr_no_rsp", 32'(m1_rsp_valid), 32'd0);
            tick();
        end
        dm_ready = 0;
        sample();
        check("wr_m1_rsp_valid", 32'(m1_rsp_valid), 32'd1);
        check("wr_m1_rsp_op", 32'(m1_rsp_op), 32'd0);
        check("wr_m1_rsp_data", m1_rsp_data, 32'd0);
        check("wr_m0_rsp_valid", 32'(m0_rsp_valid), 32'd0);
        check("wr_dmi_dropped", 32'(dmi_valid), 32'd0);
        tick();

        // ---- round-robin: 4 back-to-back reads from each master ----
        k0 = 0; k1 = 0;
        m0_valid = 1; m0_op = 2'b01; m0_addr = 7'h20;
        m1_valid = 1; m1_op = 2'b01; m1_addr = 7'h40;
        for (int t = 0; t < 8; t++) begin
            exp_m    = t % 2;
            exp_addr = (exp_m == 1) ? 7'(7'h40 + k1) : 7'(7'h20 + k0);
            sample();
            check("rr_m0_ready", 32'(m0_ready), 32'(exp_m == 0));
            check("rr_m1_ready", 32'(m1_ready), 32'(exp_m == 1));
            tick();
            if (exp_m == 0) begin
                k0++;
                if (k0 == 4) m0_valid = 0; else m0_addr = 7'(7'h20 + k0);
            end else begin
                k1++;
                if (k1 == 4) m1_valid = 0; else m1_addr = 7'(7'h40 + k1);
            end
            dm_ready = 1; dm_rsp_valid = 1; dm_rsp_data = 32'hA000_0000 | 32'(exp_addr);
            sample();
            check("rr_dmi_addr", 32'(dmi_addr), 32'(exp_addr));
            tick();
            dm_ready = 0; dm_rsp_valid = 0;
            sample();
            check("rr_m0_rsp_valid", 32'(m0_rsp_valid), 32'(exp_m == 0));
            check("rr_m1_rsp_valid", 32'(m1_rsp_valid), 32'(exp_m == 1));
            check("rr_rsp_data", (exp_m == 1) ? m1_rsp_data : m0_rsp_data,
                  32'hA000_0000 | 32'(exp_addr));
            check("rr_grant", 32'(grant), 32'(exp_m));
            tick();
        end
        sample();
        check("rr_drained_m0", 32'(m0_ready), 32'd0);
        check("rr_drained_m1", 32'(m1_ready), 32'd0);

        // ---- m0 nop: response after one cycle, DM untouched ----
        tick();
        m0_valid = 1; m0_op = 2'b00; m0_addr = 7'h05;
        sample();
        check("nop_m0_ready", 32'(m0_ready), 32'd1);
        check("nop_dmi_idle0", 32'(dmi_valid), 32'd0);
        tick();
        m0_valid = 0;
        sample();
        check("nop_m0_rsp_valid", 32'(m0_rsp_valid), 32'd1);
        check("nop_m0_rsp_op", 32'(m0_rsp_op), 32'd0);
        check("nop_m0_rsp_data", m0_rsp_data, 32'd0);
        check("nop_dmi_idle1", 32'(dmi_valid), 32'd0);
        tick();
        sample();
        check("nop_idle", 32'(busy), 32'd0);

        // ---- read with a silent DM ----
        tick();
        m0_valid = 1; m0_op = 2'b01; m0_addr = 7'h12;
        sample();
        check("to_m0_ready", 32'(m0_ready), 32'd1);
        tick();
        m0_valid = 0; dm_ready = 1;
`ifdef DMI_ARB_TIMEOUT_EN
        for (int c = 1; c <= 8; c++) begin
            sample();
            check("to_waiting_rsp", 32'(m0_rsp_valid), 32'd0);
            check("to_waiting_busy", 32'(busy), 32'd1);
            tick();
        end
        sample();
        check("to_rsp_valid", 32'(m0_rsp_valid), 32'd1);
        check("to_rsp_op", 32'(m0_rsp_op), 32'd2);
        check("to_rsp_data", m0_rsp_data, 32'd0);
        check("to_dmi_valid", 32'(dmi_valid), 32'd0);
        tick();
        dm_rsp_valid = 1; dm_rsp_data = 32'hDEAD_BEEF;
        sample();
        check("to_late_m0", 32'(m0_rsp_valid), 32'd0);
        check("to_late_m1", 32'(m1_rsp_valid), 32'd0);
        check("to_late_idle", 32'(busy), 32'd0);
        tick();
        dm_rsp_valid = 0; dm_ready = 0;
        sample();
        check("to_late_after", 32'(m0_rsp_valid), 32'd0);
        check("to_late_data", m0_rsp_data, 32'd0);
`else
        for (int c = 1; c <= 20; c++) begin
            sample();
            check("wait_no_rsp", 32'(m0_rsp_valid), 32'd0);
            check("wait_busy", 32'(busy), 32'd1);
            tick();
        end
        dm_rsp_valid = 1; dm_rsp_data = 32'h1234_5678; dm_rsp_op = 2'b10;
        tick();
        dm_rsp_valid = 0; dm_ready = 0; dm_rsp_op = 2'b00;
        sample();
        check("wait_rsp_valid", 32'(m0_rsp_valid), 32'd1);
        check("wait_rsp_data", m0_rsp_data, 32'h1234_5678);
        check("wait_rsp_op", 32'(m0_rsp_op), 32'd2);
`endif

        // ---- reset pulsed in WAIT_RSP; m0 must then win a tie ----
        tick();
        m0_valid = 1; m0_op = 2'b01; m0_addr = 7'h13; dm_ready = 1;
        sample();
        check("wr2_m0_ready", 32'(m0_ready), 32'd1);
        tick();
        m0_valid = 0;
        sample();
        tick();
        sample();
        check("mid_wait_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        m0_valid = 1; m1_valid = 1; m1_op = 2'b01; m1_addr = 7'h33;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_dmi_valid", 32'(dmi_valid), 32'd0);
        check("mid_rst_dmi_addr", 32'(dmi_addr), 32'd0);
        check("mid_rst_m0_ready", 32'(m0_ready), 32'd0);
        check("mid_rst_m1_ready", 32'(m1_ready), 32'd0);
        check("mid_rst_m0_rsp_valid", 32'(m0_rsp_valid), 32'd0);
        check("mid_rst_m1_rsp_data", m1_rsp_data, 32'd0);
        check("mid_rst_grant", 32'(grant), 32'd1);
        tick();
        reset = 1'b0;
        sample();
        check("post_rst_m0_ready", 32'(m0_ready), 32'd1);
        check("post_rst_m1_ready", 32'(m1_ready), 32'd0);
        tick();
        m0_valid = 0; m1_valid = 0;
        dm_ready = 1; dm_rsp_valid = 1; dm_rsp_data = 32'h0000_0007;
        sample();
        check("post_rst_dmi_addr", 32'(dmi_addr), 32'h13);
        tick();
        dm_ready = 0; dm_rsp_valid = 0;
        sample();
        check("post_rst_m0_rsp", 32'(m0_rsp_valid), 32'd1);
        check("post_rst_m0_data", m0_rsp_data, 32'h7);
        check("post_rst_m1_rsp", 32'(m1_rsp_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
